// File: rtl/rv32_arb_pkg.sv
// Shared definitions for the RV32 memory arbiter.
//   arb_state_e : grant state of the shared memory port
//   BE_FULL     : byte enables used for every instruction fetch
//   RUN_W       : width of the consecutive-data-grant run counter
package rv32_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_e;

  localparam logic [3:0]  BE_FULL = 4'hF;
  localparam int unsigned RUN_W   = 4;

endpackage

// File: rtl/rv32_mem_arbiter_if.sv
// Bus bundle between the RV32I core (fetch port i*, load/store port d*) and
// the shared single-ported memory (m_*), waitrequest-style handshake.
//   modport slave  : arbiter view (accepts core requests, drives the memory)
//   modport master : system view (core + memory model drive requests/responses)
interface rv32_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] iaddress;
  logic                  iread;
  logic [31:0]           ireaddata;
  logic                  iwaitrequest;

  logic [ADDR_WIDTH-1:0] daddress;
  logic                  dread;
  logic                  dwrite;
  logic [31:0]           dwritedata;
  logic [3:0]            dbyteenable;
  logic [31:0]           dreaddata;
  logic                  dwaitrequest;

  logic [ADDR_WIDTH-1:0] m_address;
  logic                  m_read;
  logic                  m_write;
  logic [31:0]           m_writedata;
  logic [3:0]            m_byteenable;
  logic [31:0]           m_readdata;
  logic                  m_waitrequest;

  modport slave (
    input  iaddress, iread, daddress, dread, dwrite, dwritedata, dbyteenable,
           m_readdata, m_waitrequest,
    output ireaddata, iwaitrequest, dreaddata, dwaitrequest,
           m_address, m_read, m_write, m_writedata, m_byteenable
  );

  modport master (
    output iaddress, iread, daddress, dread, dwrite, dwritedata, dbyteenable,
           m_readdata, m_waitrequest,
    input  ireaddata, iwaitrequest, dreaddata, dwaitrequest,
           m_address, m_read, m_write, m_writedata, m_byteenable
  );

endinterface

// File: rtl/rv32_arb_stats.sv
// Free-running stall-cycle counters for the memory arbiter (built only when
// RV32_MEM_ARBITER_STATS_EN is defined in the top).
//   clk, reset    : clock, synchronous active-high reset (clears both counts)
//   istall        : fetch is requesting and stalled this cycle
//   dstall        : data port is requesting and stalled this cycle
//   istall_cycles : number of istall cycles, wraps at 2^32
//   dstall_cycles : number of dstall cycles, wraps at 2^32
module rv32_arb_stats (
  input  logic        clk,
  input  logic        reset,
  input  logic        istall,
  input  logic        dstall,
  output logic [31:0] istall_cycles,
  output logic [31:0] dstall_cycles
);

  logic [31:0] icnt_q, icnt_d;
  logic [31:0] dcnt_q, dcnt_d;

  always_comb begin
    icnt_d = icnt_q + {31'b0, istall};
    dcnt_d = dcnt_q + {31'b0, dstall};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      icnt_q <= '0;
      dcnt_q <= '0;
    end else begin
      icnt_q <= icnt_d;
      dcnt_q <= dcnt_d;
    end
  end

  assign istall_cycles = icnt_q;
  assign dstall_cycles = dcnt_q;

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Shares one waitrequest-style memory between the RV32I fetch port and the
// load/store port. Data has priority; after MAX_DATA_RUN consecutive data
// grants with a fetch waiting, one fetch grant is forced. The master that
// does not own the port sees its waitrequest held high.
//   clk, reset : clock, synchronous active-high reset
//   bus        : rv32_mem_arbiter_if.slave (i*, d* core ports, m_* memory)
//   istall_cycles, dstall_cycles : stall counters, present only when the
//                macro RV32_MEM_ARBITER_STATS_EN is defined
// Parameters: ADDR_WIDTH (must match the interface), MAX_DATA_RUN (1..15).
module rv32_mem_arbiter
  import rv32_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned MAX_DATA_RUN = 4
) (
  input logic                clk,
  input logic                reset,
  rv32_mem_arbiter_if.slave  bus
`ifdef RV32_MEM_ARBITER_STATS_EN
  ,
  output logic [31:0]        istall_cycles,
  output logic [31:0]        dstall_cycles
`endif
);

  if (MAX_DATA_RUN < 1 || MAX_DATA_RUN > 15) begin : g_bad_max_data_run
    $error("MAX_DATA_RUN must be in 1..15");
  end

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

  arb_state_e            state_q, state_d;
  logic [RUN_W-1:0]      run_q, run_d;
  logic                  dreq;
  logic                  done;
  logic [ADDR_WIDTH-1:0] m_address_d;

  always_comb begin
    dreq             = bus.dread | bus.dwrite;
    done             = 1'b0;
    state_d          = state_q;
    run_d            = run_q;
    m_address_d      = '0;
    bus.m_read       = 1'b0;
    bus.m_write      = 1'b0;
    bus.m_writedata  = '0;
    bus.m_byteenable = '0;
    bus.iwaitrequest = 1'b1;
    bus.dwaitrequest = 1'b1;
    bus.ireaddata    = bus.m_readdata;
    bus.dreaddata    = bus.m_readdata;

    case (state_q)
      IGNT: begin
        m_address_d      = bus.iaddress;
        bus.m_read       = bus.iread;
        bus.m_byteenable = BE_FULL;
        bus.iwaitrequest = bus.m_waitrequest;
        // A dropped request ends the transfer just like an accepted one.
        done             = ~bus.iread | ~bus.m_waitrequest;
        if (done) run_d = '0;
      end
      DGNT: begin
        m_address_d      = bus.daddress;
        bus.m_read       = bus.dread & ~bus.dwrite;
        bus.m_write      = bus.dwrite;
        bus.m_writedata  = bus.dwritedata;
        bus.m_byteenable = bus.dbyteenable;
        bus.dwaitrequest = bus.m_waitrequest;
        done             = ~dreq | ~bus.m_waitrequest;
        if (done) begin
          if (!bus.iread)          run_d = '0;
          else if (run_q < RUN_MAX) run_d = run_q + 1'b1;
        end
      end
      default: done = 1'b1;
    endcase

    // Arbitrate with the run count already updated by this completion, so
    // the forced fetch follows exactly MAX_DATA_RUN data grants.
    if (done) begin
      if (dreq && bus.iread && run_d == RUN_MAX) state_d = IGNT;
      else if (dreq)                              state_d = DGNT;
      else if (bus.iread)                         state_d = IGNT;
      else                                        state_d = IDLE;
    end
  end

  assign bus.m_address = m_address_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(bus.dread && bus.dwrite))
        else $error("dread and dwrite asserted together");
    end
  end

`ifdef RV32_MEM_ARBITER_STATS_EN
  rv32_arb_stats u_stats (
    .clk           (clk),
    .reset         (reset),
    .istall        (bus.iread & bus.iwaitrequest),
    .dstall        (dreq & bus.dwaitrequest),
    .istall_cycles (istall_cycles),
    .dstall_cycles (dstall_cycles)
  );
`endif

endmodule
